store_sequencer: RTL
====================

Name: store_sequencer

Overview:
- Sits between the execute stage and the synchronous data memory write port.
- Accepts one store request per handshake and generates byte-enable masks and lane-shifted write data.
- Misaligned stores are split into two memory beats: the current word and the next word.
- Asserts a busy indication so the pipeline can stall until the store has fully retired to memory.

Parameters:
- WIDTH, 32, data and address width. Only 32 is supported.
- SPLIT_MAX, 2, maximum number of memory beats per store. Fixed; exists for documentation and assertions only.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_i  in  1  store request valid.
- req_ready_o  out  1  sequencer can accept a request.
- req_addr_i  in  WIDTH  byte address of the store.
- req_func3_2lsb_i  in  2  store size: 00 byte, 01 half, 10 word, 11 illegal.
- req_data_i  in  WIDTH  store data, right-justified.
- mem_req_o  out  1  memory write beat valid.
- mem_gnt_i  in  1  memory accepts the beat this cycle.
- mem_addr_o  out  WIDTH  word-aligned beat address; low 2 bits always 00.
- mem_wea_o  out  4  byte write enables for the beat.
- mem_wdata_o  out  WIDTH  lane-aligned write data.
- busy_o  out  1  store in flight, used as a pipeline stall.
- done_o  out  1  one-cycle pulse when the store has completed.
- misalign_o  out  1  pulse on a misaligned-store trap; only exists under the optional feature.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - mem_req_o=0, mem_wea_o=0, mem_addr_o=0, mem_wdata_o=0, done_o=0, busy_o=0, misalign_o=0.
  - req_ready_o=1 after reset release.
- States are IDLE, BEAT0, BEAT1, DONE.
- IDLE:
  - req_ready_o=1.
  - A request is accepted when req_valid_i and req_ready_o are both high.
  - On acceptance, the sequencer registers addr, size and data.
  - Next state is BEAT0, or DONE if size is 11.
- Mask and data computation, done at acceptance and registered:
  - off = addr[1:0].
  - base = 0001 (byte), 0011 (half) or 1111 (word).
  - m8 = base << off, an 8-bit value.
  - d64 = {32'b0, data} << (8*off), a 64-bit value.
  - Split = (m8[7:4] != 0).
- BEAT0:
  - mem_req_o=1, mem_addr_o={addr[31:2],00}, mem_wea_o=m8[3:0], mem_wdata_o=d64[31:0].
  - All outputs are held stable until mem_gnt_i.
  - On grant, go to BEAT1 if split, otherwise DONE.
- BEAT1:
  - mem_addr_o={addr[31:2],00}+4, which wraps modulo 2^32 (0xFFFFFFFC+4 gives 0x00000000).
  - mem_wea_o=m8[7:4], mem_wdata_o=d64[63:32].
  - On grant, go to DONE.
- DONE:
  - done_o=1 for exactly one cycle, then return to IDLE.
  - req_ready_o=0 in DONE.
- Outside BEATx: mem_req_o=0 and mem_wea_o=0 in every state other than BEAT0 and BEAT1.
- busy_o=1 in BEAT0, BEAT1 and DONE.
- Latency:
  - Accepted at cycle N, first beat presented at N+1.
  - Aligned store with an immediate grant: done_o at N+2.
  - Split store with immediate grants: done_o at N+3.
- Grant held low: stall indefinitely with no timeout; beat outputs stay unchanged.
- Illegal size 11: no memory beat is issued; done_o still pulses at N+1.
- Stray grant: mem_gnt_i while mem_req_o=0 is ignored.
- Reset mid-beat: the state aborts to IDLE, and a partial split store (BEAT0 already written) is not rolled back.
- Back-to-back requests: a new request is accepted no earlier than the cycle after the done_o pulse, so there is at most one store in flight.

Optional Feature:
- Macro: STORE_SEQ_MISALIGN_TRAP_EN.
- Defined:
  - Split stores are not issued.
  - A request with split=1 goes from IDLE directly to DONE with no memory beat.
  - misalign_o pulses together with done_o; the BEAT1 state is removed.
- Undefined: splitting behaves as described above, and misalign_o is absent from the port list.

Decomposition:
- Shared package store_seq_pkg holds:
  - state enum (IDLE/BEAT0/BEAT1/DONE);
  - size constants SZ_B=00, SZ_H=01, SZ_W=10;
  - mask constants MASK_B=0001, MASK_H=0011, MASK_W=1111.
- One sub-module, store_lane_align: combinational; inputs off, size and data; outputs m8, d64 and split. It is instantiated once in front of the request registers.

Test Plan:
- Aligned word store: addr=0x100, size=10, data=0xDEADBEEF, grant tied 1 -> one beat with addr 0x100, wea=1111, wdata=0xDEADBEEF; done_o at N+2.
- Byte store: addr=0x203, size=00, data=0x000000AB -> one beat with addr 0x200, wea=1000, wdata=0xAB000000.
- Split half store: addr=0x0FF, size=01, data=0x1234, grants=1 -> beat0 addr 0x0FC, wea=1000, wdata=0x34000000; beat1 addr 0x100, wea=0001, wdata=0x00000012; done_o at N+3.
- Split word with wrap: addr=0xFFFFFFFE, size=10, data=0xAABBCCDD, mem_gnt_i low for 3 cycles on beat0 -> beat0 held stable, addr 0xFFFFFFFC, wea=1100, wdata=0xCCDD0000; beat1 addr 0x0, wea=0011, wdata=0x0000AABB.
- Illegal size 11 and reset mid-BEAT1:
  - size 11 -> no mem_req_o; done_o at N+1.
  - rst_n low during BEAT1 -> all outputs 0 immediately (async); req_ready_o=1 after release.
- Trap build (macro defined): addr=0x101, size=10 -> no mem_req_o; done_o and misalign_o pulse together at N+1.

Source files
------------

// File: rtl/store_seq_pkg.sv
// Shared types and constants for the store sequencer.
// No logic; enum, store-size codes and base byte-enable masks.
// With STORE_SEQ_MISALIGN_TRAP_EN defined the BEAT1 state does not exist.
package store_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
`ifndef STORE_SEQ_MISALIGN_TRAP_EN
    BEAT1 = 2'd2,
`endif
    DONE  = 2'd3
  } state_e;

  // Store size encoding as carried by func3[1:0]
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  // Byte-enable pattern for a store at offset 0
  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

endpackage

// File: rtl/store_seq_if.sv
// Request and memory-port bundle of the store sequencer.
// slave = sequencer view, master = execute stage / memory / bench view.
// misalign_o exists only with STORE_SEQ_MISALIGN_TRAP_EN defined.
interface store_seq_if #(
  parameter int WIDTH = 32
);
  logic             req_valid_i;
  logic             req_ready_o;
  logic [WIDTH-1:0] req_addr_i;
  logic [1:0]       req_func3_2lsb_i;
  logic [WIDTH-1:0] req_data_i;
  logic             mem_req_o;
  logic             mem_gnt_i;
  logic [WIDTH-1:0] mem_addr_o;
  logic [3:0]       mem_wea_o;
  logic [WIDTH-1:0] mem_wdata_o;
  logic             busy_o;
  logic             done_o;
`ifdef STORE_SEQ_MISALIGN_TRAP_EN
  logic             misalign_o;
`endif

  modport slave (
    input  req_valid_i, req_addr_i, req_func3_2lsb_i, req_data_i, mem_gnt_i,
    output req_ready_o, mem_req_o, mem_addr_o, mem_wea_o, mem_wdata_o,
    output busy_o, done_o
`ifdef STORE_SEQ_MISALIGN_TRAP_EN
    , output misalign_o
`endif
  );

  modport master (
    output req_valid_i, req_addr_i, req_func3_2lsb_i, req_data_i, mem_gnt_i,
    input  req_ready_o, mem_req_o, mem_addr_o, mem_wea_o, mem_wdata_o,
    input  busy_o, done_o
`ifdef STORE_SEQ_MISALIGN_TRAP_EN
    , input misalign_o
`endif
  );

endinterface

// File: rtl/store_seq_lane_align.sv
// Byte-lane alignment of a store: 8-bit enable mask, 64-bit shifted data, split flag.
// Purely combinational, zero latency.
// No flow control; illegal size yields an empty mask and no split.
module store_lane_align
  import store_seq_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] data_i,
  output logic [7:0]  m8_o,
  output logic [63:0] d64_o,
  output logic        split_o
);

  logic [3:0] base;

  // Base mask for the store size at offset 0
  always_comb begin
    base = 4'b0000;
    case (size_i)
      SZ_B:    base = MASK_B;
      SZ_H:    base = MASK_H;
      SZ_W:    base = MASK_W;
      default: base = 4'b0000;
    endcase
  end

  // Shift into the two-word window; anything landing in the upper word means a second beat
  assign m8_o    = {4'b0000, base} << off_i;
  assign d64_o   = {32'b0, data_i} << {off_i, 3'b000};
  assign split_o = |m8_o[7:4];

endmodule

// File: rtl/store_sequencer.sv
// Store sequencer: turns one store request into one or two lane-aligned memory write beats.
// Latency: beat at N+1; done_o at N+2 (aligned) / N+3 (split) with immediate grants, N+1 for illegal size.
// Backpressure: one store in flight; beats hold until mem_gnt_i; optional STORE_SEQ_MISALIGN_TRAP_EN traps splits.
module store_sequencer
  import store_seq_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int SPLIT_MAX = 2
) (
  input logic         clk,
  input logic         rst_n,
  store_seq_if.slave  bus
);

  if (WIDTH != 32) begin : g_width_check
    $error("store_sequencer: only WIDTH=32 is supported");
  end
  if (SPLIT_MAX != 2) begin : g_split_check
    $error("store_sequencer: SPLIT_MAX is fixed at 2");
  end

  logic [7:0]       m8;
  logic [63:0]      d64;
  logic             split;

  state_e           state_q;
  logic             mem_req_q;
  logic [WIDTH-1:0] mem_addr_q;
  logic [3:0]       mem_wea_q;
  logic [WIDTH-1:0] mem_wdata_q;
`ifdef STORE_SEQ_MISALIGN_TRAP_EN
  logic             misalign_q;
`else
  logic             split_q;
  logic [3:0]       wea_hi_q;
  logic [WIDTH-1:0] wdata_hi_q;
`endif

  store_lane_align u_lane_align (
    .off_i   (bus.req_addr_i[1:0]),
    .size_i  (bus.req_func3_2lsb_i),
    .data_i  (bus.req_data_i),
    .m8_o    (m8),
    .d64_o   (d64),
    .split_o (split)
  );

  // Sequencer FSM: accept in IDLE, present beats until granted, pulse done for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wea_q   <= 4'b0000;
      mem_wdata_q <= '0;
`ifdef STORE_SEQ_MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`else
      split_q     <= 1'b0;
      wea_hi_q    <= 4'b0000;
      wdata_hi_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid_i) begin
            if (bus.req_func3_2lsb_i == SZ_X) begin
              state_q <= DONE;
            end
`ifdef STORE_SEQ_MISALIGN_TRAP_EN
            else if (split) begin
              state_q    <= DONE;
              misalign_q <= 1'b1;
            end
`endif
            else begin
              state_q     <= BEAT0;
              mem_req_q   <= 1'b1;
              mem_addr_q  <= {bus.req_addr_i[WIDTH-1:2], 2'b00};
              mem_wea_q   <= m8[3:0];
              mem_wdata_q <= d64[31:0];
`ifndef STORE_SEQ_MISALIGN_TRAP_EN
              split_q     <= split;
              wea_hi_q    <= m8[7:4];
              wdata_hi_q  <= d64[63:32];
`endif
            end
          end
        end
        BEAT0: begin
          if (bus.mem_gnt_i) begin
`ifndef STORE_SEQ_MISALIGN_TRAP_EN
            if (split_q) begin
              // Next word; the adder wraps naturally at the top of the address space
              state_q     <= BEAT1;
              mem_addr_q  <= mem_addr_q + WIDTH'(4);
              mem_wea_q   <= wea_hi_q;
              mem_wdata_q <= wdata_hi_q;
            end else
`endif
            begin
              state_q   <= DONE;
              mem_req_q <= 1'b0;
              mem_wea_q <= 4'b0000;
            end
          end
        end
`ifndef STORE_SEQ_MISALIGN_TRAP_EN
        BEAT1: begin
          if (bus.mem_gnt_i) begin
            state_q   <= DONE;
            mem_req_q <= 1'b0;
            mem_wea_q <= 4'b0000;
          end
        end
`endif
        DONE: begin
          state_q <= IDLE;
`ifdef STORE_SEQ_MISALIGN_TRAP_EN
          misalign_q <= 1'b0;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_o = (state_q == IDLE);
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.done_o      = (state_q == DONE);
  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wea_o   = mem_wea_q;
  assign bus.mem_wdata_o = mem_wdata_q;
`ifdef STORE_SEQ_MISALIGN_TRAP_EN
  assign bus.misalign_o  = misalign_q;
`endif

endmodule
